// File: rtl/sram_arb_pkg.sv
// Shared constants and request bundle for the unified I/D SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 32;
    localparam int unsigned SRAM_DATA_W = 32;
    localparam int unsigned SRAM_BE_W   = SRAM_DATA_W / 8;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    typedef struct packed {
        logic                   req;
        logic [SRAM_BE_W-1:0]   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_arb_resp.sv
// Read-response tracker: routes the 1-cycle SRAM read data to the issuing port
// and holds each port's last read word until that port's next read returns.
module sram_arb_resp
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd_i,
    input  logic              i_rd_d,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_rvalid_i,
    output logic [DATA_W-1:0] o_rdata_i,
    output logic              o_rvalid_d,
    output logic [DATA_W-1:0] o_rdata_d
);

    logic              r_pending;
    logic              r_owner;
    logic [DATA_W-1:0] r_hold_i;
    logic [DATA_W-1:0] r_hold_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_owner   <= PORT_I;
            r_hold_i  <= '0;
            r_hold_d  <= '0;
        end else begin
            r_pending <= i_rd_i | i_rd_d;
            if (i_rd_i | i_rd_d) begin
                r_owner <= i_rd_d ? PORT_D : PORT_I;
            end
            if (o_rvalid_i) begin
                r_hold_i <= i_sram_rdata;
            end
            if (o_rvalid_d) begin
                r_hold_d <= i_sram_rdata;
            end
        end
    end

    assign o_rvalid_i = r_pending & (r_owner == PORT_I);
    assign o_rvalid_d = r_pending & (r_owner == PORT_D);

    // The SRAM output register supplies the word during the valid cycle; the hold takes over after.
    assign o_rdata_i = o_rvalid_i ? i_sram_rdata : r_hold_i;
    assign o_rdata_d = o_rvalid_d ? i_sram_rdata : r_hold_d;

endmodule

// File: rtl/unified_sram_arbiter.sv
// Shares one single-port SRAM between instruction fetch (I) and load/store (D),
// one access per cycle, with I anti-starvation or round-robin selection.
module unified_sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = SRAM_ADDR_W,
    parameter int unsigned DATA_W   = SRAM_DATA_W,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned RR_MODE  = ARB_FIXED,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_req,
    input  logic [DATA_W/8-1:0] i_we,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,

    output logic [CNT_W-1:0]    i_gnt_cnt,
    output logic [CNT_W-1:0]    d_gnt_cnt
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned SC_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    // Parameter-sized form of sram_req_t.
    typedef struct packed {
        logic              req;
        logic [BE_W-1:0]   we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_bus_t;

    req_bus_t         w_req_i;
    req_bus_t         w_req_d;
    req_bus_t         w_sel;
    logic             w_i_prio;
    logic             w_i_win;
    logic             w_d_win;
    logic             w_rd_i;
    logic             w_rd_d;

    logic [SC_W-1:0]  r_starve_cnt;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_i_gnt_cnt;
    logic [CNT_W-1:0] r_d_gnt_cnt;

    assign w_req_i = '{req: i_req, we: i_we, addr: i_addr, wdata: i_wdata};
    assign w_req_d = '{req: d_req, we: d_we, addr: d_addr, wdata: d_wdata};

    // Tie-break: does I win when both ports request?
    always_comb begin
        w_i_prio = 1'b0;
        if (RR_MODE == ARB_RR) begin
            w_i_prio = (r_last_grant == PORT_D);
        end else begin
            w_i_prio = (r_starve_cnt == SC_W'(MAX_WAIT));
        end
    end

    assign w_i_win = ~reset & i_req & (~d_req | w_i_prio);
    assign w_d_win = ~reset & d_req & ~w_i_win;
    assign i_gnt   = w_i_win;
    assign d_gnt   = w_d_win;

    always_comb begin
        w_sel = '0;
        if (w_i_win) begin
            w_sel = w_req_i;
        end else if (w_d_win) begin
            w_sel = w_req_d;
        end
    end

    assign sram_en    = w_sel.req;
    assign sram_we    = w_sel.we;
    assign sram_addr  = w_sel.addr;
    assign sram_wdata = w_sel.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
            r_last_grant <= PORT_D;
            r_i_gnt_cnt  <= '0;
            r_d_gnt_cnt  <= '0;
        end else begin
            if (w_i_win) begin
                r_i_gnt_cnt  <= r_i_gnt_cnt + CNT_W'(1);
                r_last_grant <= PORT_I;
            end else if (w_d_win) begin
                r_d_gnt_cnt  <= r_d_gnt_cnt + CNT_W'(1);
                r_last_grant <= PORT_D;
            end
            // Consecutive denied I cycles, saturating at the forcing threshold.
            if ((RR_MODE == ARB_FIXED) && i_req && !w_i_win) begin
                if (r_starve_cnt != SC_W'(MAX_WAIT)) begin
                    r_starve_cnt <= r_starve_cnt + SC_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    assign i_gnt_cnt = r_i_gnt_cnt;
    assign d_gnt_cnt = r_d_gnt_cnt;

    assign w_rd_i = w_i_win & ~(|i_we);
    assign w_rd_d = w_d_win & ~(|d_we);

    sram_arb_resp #(
        .DATA_W (DATA_W)
    ) u_resp (
        .clk          (clk),
        .reset        (reset),
        .i_rd_i       (w_rd_i),
        .i_rd_d       (w_rd_d),
        .i_sram_rdata (sram_rdata),
        .o_rvalid_i   (i_rvalid),
        .o_rdata_i    (i_rdata),
        .o_rvalid_d   (d_rvalid),
        .o_rdata_d    (d_rdata)
    );

endmodule

// File: tb/tb_unified_sram_arbiter.sv
// Directed bench for unified_sram_arbiter: a fixed-priority instance (0) and a
// round-robin instance (1) share stimulus; read responses go through a scoreboard.
module tb_unified_sram_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        i_req, d_req;
    logic [3:0]  i_we, d_we;
    logic [31:0] i_addr, d_addr, i_wdata, d_wdata;

    logic        i_gnt [2];
    logic        d_gnt [2];
    logic        i_rvalid [2];
    logic        d_rvalid [2];
    logic        sram_en [2];
    logic [31:0] i_rdata [2];
    logic [31:0] d_rdata [2];
    logic [31:0] sram_addr [2];
    logic [31:0] sram_wdata [2];
    logic [31:0] sram_rdata [2];
    logic [3:0]  sram_we [2];
    logic [15:0] i_gnt_cnt [2];
    logic [15:0] d_gnt_cnt [2];

    unified_sram_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .RR_MODE(0), .CNT_W(16)
    ) dut0 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .sram_en(sram_en[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
        .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]),
        .i_gnt_cnt(i_gnt_cnt[0]), .d_gnt_cnt(d_gnt_cnt[0])
    );

    unified_sram_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .RR_MODE(1), .CNT_W(16)
    ) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .sram_en(sram_en[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
        .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]),
        .i_gnt_cnt(i_gnt_cnt[1]), .d_gnt_cnt(d_gnt_cnt[1])
    );

    localparam logic [31:0] W_I = 32'hDEADBEEF;
    localparam logic [31:0] W_D = 32'hA5A50200;
    localparam logic [31:0] W_X = 32'h12345678;

    // SRAM models: word index = addr[9:2], 1-cycle read latency.
    logic [31:0] mem [2][256];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mem[k][8'h00] <= W_I;
                mem[k][8'h80] <= W_D;
            end else if (sram_en[k]) begin
                if (sram_we[k] != 4'h0)
                    mem[k][sram_addr[k][9:2]] <= merge(mem[k][sram_addr[k][9:2]], sram_wdata[k], sram_we[k]);
                else
                    sram_rdata[k] <= mem[k][sram_addr[k][9:2]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard queue index = instance*2 + port (0 = I, 1 = D).
    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t sb [4][$];

    task automatic push(input int k, input int port, input logic [31:0] data);
        rsp_t e;
        e.data = data;
        e.due  = cyc + 1;
        sb[k*2 + port].push_back(e);
    endtask

    logic        mon_rv;
    logic [31:0] mon_rd;
    always @(negedge clk) begin
        if (!reset) begin
            for (int s = 0; s < 4; s++) begin
                mon_rv = (s % 2 == 0) ? i_rvalid[s/2] : d_rvalid[s/2];
                mon_rd = (s % 2 == 0) ? i_rdata[s/2]  : d_rdata[s/2];
                if (sb[s].size() > 0 && sb[s][0].due == cyc) begin
                    chk($sformatf("rvalid_q%0d_c%0d", s, cyc), 64'(mon_rv), 64'(1));
                    chk($sformatf("rdata_q%0d_c%0d", s, cyc), 64'(mon_rd), 64'(sb[s][0].data));
                    void'(sb[s].pop_front());
                end else if (mon_rv) begin
                    chk($sformatf("rvalid_spurious_q%0d_c%0d", s, cyc), 64'(mon_rv), 64'(0));
                end
            end
        end
    end

    task automatic idle();
        i_req = 1'b0; i_we = '0; i_addr = '0; i_wdata = '0;
        d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input int k, input logic ei, input logic ed);
        chk($sformatf("%s_i_gnt%0d", tag, k), 64'(i_gnt[k]), 64'(ei));
        chk($sformatf("%s_d_gnt%0d", tag, k), 64'(d_gnt[k]), 64'(ed));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle();
        for (int s = 0; s < 4; s++) sb[s].delete();
        repeat (n) next();
        reset = 1'b0;
    endtask

    logic e_i;

    initial begin
        idle();
        reset = 1'b1;
        next();
        next();

        // Grants and sram_en are suppressed while reset is high.
        i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk_gnt("in_reset", k, 1'b0, 1'b0);
            chk($sformatf("in_reset_en%0d", k), 64'(sram_en[k]), 64'(0));
        end
        next();
        reset = 1'b0;
        idle();

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_i_rvalid%0d", k), 64'(i_rvalid[k]), 64'(0));
            chk($sformatf("rst_d_rvalid%0d", k), 64'(d_rvalid[k]), 64'(0));
            chk($sformatf("rst_i_rdata%0d", k), 64'(i_rdata[k]), 64'(0));
            chk($sformatf("rst_d_rdata%0d", k), 64'(d_rdata[k]), 64'(0));
            chk($sformatf("rst_i_cnt%0d", k), 64'(i_gnt_cnt[k]), 64'(0));
            chk($sformatf("rst_d_cnt%0d", k), 64'(d_gnt_cnt[k]), 64'(0));
        end
        next();

        // Single I read, then hold for ten cycles.
        i_req = 1'b1; i_addr = 32'h1c000000;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk_gnt("single", k, 1'b1, 1'b0);
            chk($sformatf("single_en%0d", k), 64'(sram_en[k]), 64'(1));
            chk($sformatf("single_addr%0d", k), 64'(sram_addr[k]), 64'(32'h1c000000));
            push(k, 0, W_I);
        end
        next();
        idle();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("hold_i_rdata%0d_c%0d", k, c), 64'(i_rdata[k]), 64'(W_I));
                chk($sformatf("hold_d_rdata%0d_c%0d", k, c), 64'(d_rdata[k]), 64'(0));
                chk($sformatf("idle_addr%0d_c%0d", k, c), 64'(sram_addr[k]), 64'(0));
            end
            next();
        end

        // Both ports reading continuously: starvation guard on 0, alternation on 1.
        do_reset(2);
        i_req = 1'b1; i_addr = 32'h1c000000;
        d_req = 1'b1; d_addr = 32'h00000200;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e_i = (c == 4 || c == 9);
            chk_gnt($sformatf("fixed_c%0d", c), 0, e_i, !e_i);
            push(0, e_i ? 0 : 1, e_i ? W_I : W_D);
            e_i = (c % 2 == 0);
            chk_gnt($sformatf("rr_c%0d", c), 1, e_i, !e_i);
            push(1, e_i ? 0 : 1, e_i ? W_I : W_D);
            next();
        end
        idle();
        @(negedge clk);
        chk("fixed_i_cnt", 64'(i_gnt_cnt[0]), 64'(2));
        chk("fixed_d_cnt", 64'(d_gnt_cnt[0]), 64'(8));
        chk("rr_i_cnt", 64'(i_gnt_cnt[1]), 64'(5));
        chk("rr_d_cnt", 64'(d_gnt_cnt[1]), 64'(5));
        next();

        // D write then read back the same word.
        d_req = 1'b1; d_we = 4'hF; d_addr = 32'h00000100; d_wdata = W_X;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk_gnt("wr", k, 1'b0, 1'b1);
            chk($sformatf("wr_we%0d", k), 64'(sram_we[k]), 64'(4'hF));
            chk($sformatf("wr_wdata%0d", k), 64'(sram_wdata[k]), 64'(W_X));
            chk($sformatf("wr_addr%0d", k), 64'(sram_addr[k]), 64'(32'h100));
        end
        next();
        d_we = 4'h0; d_wdata = '0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk_gnt("rd", k, 1'b0, 1'b1);
            chk($sformatf("rd_we%0d", k), 64'(sram_we[k]), 64'(0));
            chk($sformatf("wr_keeps_d_rdata%0d", k), 64'(d_rdata[k]), 64'(W_D));
            push(k, 1, W_X);
        end
        next();
        idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("rd_i_rdata_kept%0d", k), 64'(i_rdata[k]), 64'(W_I));
        next();
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("rd_d_rdata_held%0d", k), 64'(d_rdata[k]), 64'(W_X));
        next();

        // Reset while an I read is pending.
        i_req = 1'b1; i_addr = 32'h1c000000;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk_gnt("prerst", k, 1'b1, 1'b0);
        next();
        idle();
        reset = 1'b1;
        for (int s = 0; s < 4; s++) sb[s].delete();
        next();
        reset = 1'b0;
        d_req = 1'b1; d_addr = 32'h00000200;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst_i_rvalid%0d", k), 64'(i_rvalid[k]), 64'(0));
            chk($sformatf("midrst_i_rdata%0d", k), 64'(i_rdata[k]), 64'(0));
            chk($sformatf("midrst_d_rdata%0d", k), 64'(d_rdata[k]), 64'(0));
            chk($sformatf("midrst_i_cnt%0d", k), 64'(i_gnt_cnt[k]), 64'(0));
            chk($sformatf("midrst_d_cnt%0d", k), 64'(d_gnt_cnt[k]), 64'(0));
            chk_gnt("postrst_zero_wait", k, 1'b0, 1'b1);
            push(k, 1, W_D);
        end
        next();

        // First tie after reset: D on the fixed instance, I on round-robin.
        i_req = 1'b1; i_addr = 32'h1c000000;
        @(negedge clk);
        chk_gnt("postrst_tie", 0, 1'b0, 1'b1);
        push(0, 1, W_D);
        chk_gnt("postrst_tie", 1, 1'b1, 1'b0);
        push(1, 0, W_I);
        next();
        idle();

        repeat (3) begin
            @(negedge clk);
            next();
        end
        for (int s = 0; s < 4; s++)
            chk($sformatf("sb_drain_q%0d", s), 64'(sb[s].size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
